// File: rtl/currctrl_dbg_pkg.sv
// currctrl_dbg_pkg: shared state encoding and sizes for the debug capture controller
package currctrl_dbg_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} dbg_state_e;
  localparam int DBG_ADDR_W = 9;
  localparam int DBG_DATA_W = 32;
  localparam int DBG_DEPTH = 2 ** DBG_ADDR_W;
endpackage

// File: rtl/currctrl_dbg_decimator.sv
// currctrl_dbg_decimator: passes one of every (divider+1) valid samples while enabled
module currctrl_dbg_decimator #(
  parameter int DECIM_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               en,
  input  logic               sample_valid,
  input  logic [DECIM_W-1:0] cfg_decim,
  output logic               accept
);
  logic [DECIM_W-1:0] cnt, lat;
  assign accept = en & sample_valid & cnt == lat;
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      lat <= '0;
    end else if (load) begin
      cnt <= '0;
      lat <= cfg_decim;
    end else if (en & sample_valid)
      cnt <= accept ? '0 : cnt + DECIM_W'(1);
endmodule

// File: rtl/currctrl_debug_capture_ctrl.sv
// currctrl_debug_capture_ctrl: circular debug-RAM capture sequencer with trigger and post-trigger window
// CURRCTRL_DBG_TSTAMP_EN replaces the top data byte with an accepted-sample count since arm
module currctrl_debug_capture_ctrl import currctrl_dbg_pkg::*; #(
  parameter int ADDR_W  = DBG_ADDR_W,
  parameter int DATA_W  = DBG_DATA_W,
  parameter int DECIM_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_arm,
  input  logic                cfg_abort,
  input  logic [ADDR_W-1:0]   cfg_post_count,
  input  logic [DECIM_W-1:0]  cfg_decim,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample_data,
  input  logic                trig_in,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [1:0]          status_state,
  output logic                status_done,
  output logic                status_wrapped,
  output logic [ADDR_W-1:0]   status_trig_addr
);
  dbg_state_e state, state_nx;
  logic trig_q, pend, wrapped, arm_go, post_full, active, accept, trig_ev;
  logic [ADDR_W-1:0] wr_ptr, addr_hold, post_cnt, post_l, trig_addr;
  logic [DATA_W-1:0] data_q, wdata_nx;
  assign arm_go = cfg_arm & ~cfg_abort & (state == IDLE | state == DONE);
  assign post_full = state == POST && post_cnt == post_l;
  assign active = (state == ARMED | state == POST) & ~post_full;
  assign trig_ev = trig_in & ~trig_q & state == ARMED;
  currctrl_dbg_decimator #(.DECIM_W(DECIM_W)) u_decim (
    .clk(clk), .reset(reset), .load(arm_go), .en(active),
    .sample_valid(sample_valid), .cfg_decim(cfg_decim), .accept(accept)
  );
`ifdef CURRCTRL_DBG_TSTAMP_EN
  logic [7:0] ts;
  always_ff @(posedge clk) ts <= (reset | arm_go) ? '0 : accept ? ts + 8'd1 : ts;
  assign wdata_nx = {ts, sample_data[DATA_W-9:0]};
`else
  assign wdata_nx = sample_data;
`endif
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = cfg_abort ? IDLE :
               arm_go    ? ARMED :
               trig_ev   ? (post_l == '0 ? DONE : POST) :
               post_full ? DONE : state;
  // A sample accepted in the trigger cycle still belongs to the pre-trigger window.
  always_ff @(posedge clk)
    if (reset) begin
      trig_q    <= 1'b0;
      pend      <= 1'b0;
      wrapped   <= 1'b0;
      wr_ptr    <= '0;
      addr_hold <= '0;
      post_cnt  <= '0;
      post_l    <= '0;
      trig_addr <= '0;
      data_q    <= '0;
    end else begin
      trig_q <= trig_in;
      pend   <= accept & ~cfg_abort;
      if (accept) data_q <= wdata_nx;
      if (pend) begin
        addr_hold <= wr_ptr;
        wr_ptr    <= wr_ptr + ADDR_W'(1);
        if (&wr_ptr) wrapped <= 1'b1;
      end
      if (accept && state == POST) post_cnt <= post_cnt + ADDR_W'(1);
      if (trig_ev) trig_addr <= wr_ptr + ADDR_W'(pend) + ADDR_W'(accept);
      if (arm_go) begin
        wr_ptr    <= '0;
        wrapped   <= 1'b0;
        trig_addr <= '0;
        post_cnt  <= '0;
        post_l    <= cfg_post_count;
      end
    end
  always_comb begin
    status_state   = state;
    status_done    = state == DONE;
    ram_write      = pend;
    ram_chipselect = pend;
    ram_byteenable = {(DATA_W/8){pend}};
    ram_address    = pend ? wr_ptr : addr_hold;
  end
  assign ram_writedata    = data_q;
  assign status_wrapped   = wrapped;
  assign status_trig_addr = trig_addr;
endmodule

// File: tb/tb_currctrl_debug_capture_ctrl.sv
// tb_currctrl_debug_capture_ctrl: vector table, corner sequences and random traffic against a count-based model
module tb_currctrl_debug_capture_ctrl;
  logic clk = 1'b0;
  logic reset, cfg_arm, cfg_abort, sample_valid, trig_in;
  logic [8:0] cfg_post_count;
  logic [7:0] cfg_decim;
  logic [31:0] sample_data;
  logic [8:0] ram_address, status_trig_addr;
  logic [31:0] ram_writedata;
  logic [3:0] ram_byteenable;
  logic ram_chipselect, ram_write, status_done, status_wrapped;
  logic [1:0] status_state;
  int checks = 0, errors = 0;

  currctrl_debug_capture_ctrl dut (
    .clk(clk), .reset(reset), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
    .cfg_post_count(cfg_post_count), .cfg_decim(cfg_decim),
    .sample_valid(sample_valid), .sample_data(sample_data), .trig_in(trig_in),
    .ram_address(ram_address), .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .status_state(status_state),
    .status_done(status_done), .status_wrapped(status_wrapped), .status_trig_addr(status_trig_addr)
  );

  always #5 clk = ~clk;

  // Model: sample k since arm lands at address k mod 512; acceptance is every (decim+1)-th valid sample.
  int m_state, m_vc, m_acc, m_post, m_tgt, m_dec, m_taddr, m_hold, m_waddr;
  logic m_trig_q, m_wr, m_wrapped;
  logic [31:0] m_wdata;

  task automatic model(input logic r, a, ab, input int pc, dc, input logic v, input logic [31:0] d, input logic t);
    logic full, cap, acc, ev, arm_ok;
    int ns;
    if (r) begin
      {m_state, m_vc, m_acc, m_post, m_tgt, m_dec, m_taddr, m_hold, m_waddr} = '0;
      {m_trig_q, m_wr, m_wrapped} = '0;
      m_wdata = '0;
    end else begin
      full = m_state == 2 && m_post >= m_tgt;
      cap = (m_state == 1 || m_state == 2) && !full;
      acc = cap && v && ((m_vc + 1) % (m_dec + 1) == 0);
      if (cap && v) m_vc++;
      ev = t && !m_trig_q && m_state == 1;
      m_trig_q = t;
      if (m_wr) begin
        m_hold = m_waddr;
        if (m_waddr == 511) m_wrapped = 1'b1;
      end
      m_wr = acc && !ab;
      if (acc) begin
        m_waddr = m_acc % 512;
`ifdef CURRCTRL_DBG_TSTAMP_EN
        m_wdata = {8'(m_acc % 256), d[23:0]};
`else
        m_wdata = d;
`endif
        m_acc++;
        if (m_state == 2) m_post++;
      end
      if (ev) m_taddr = m_acc % 512;
      arm_ok = a && !ab && (m_state == 0 || m_state == 3);
      ns = ab ? 0 : arm_ok ? 1 : ev ? (m_tgt == 0 ? 3 : 2) : full ? 3 : m_state;
      if (arm_ok) begin
        {m_vc, m_acc, m_post, m_taddr} = '0;
        m_wrapped = 1'b0;
        m_tgt = pc;
        m_dec = dc;
      end
      m_state = ns;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, a, ab, input int pc, dc, input logic v, input logic [31:0] d, input logic t);
    reset = r; cfg_arm = a; cfg_abort = ab; cfg_post_count = 9'(pc); cfg_decim = 8'(dc);
    sample_valid = v; sample_data = d; trig_in = t;
    model(r, a, ab, pc, dc, v, d, t);
    @(posedge clk);
    #1;
    chk("state", 32'(status_state), 32'(m_state));
    chk("done", 32'(status_done), 32'(m_state == 3));
    chk("write", 32'(ram_write), 32'(m_wr));
    chk("cs", 32'(ram_chipselect), 32'(m_wr));
    chk("be", 32'(ram_byteenable), m_wr ? 32'hF : 32'h0);
    chk("addr", 32'(ram_address), 32'(m_wr ? m_waddr : m_hold));
    chk("wrapped", 32'(status_wrapped), 32'(m_wrapped));
    chk("trig_addr", 32'(status_trig_addr), 32'(m_taddr));
    if (m_wr) chk("wdata", ram_writedata, m_wdata);
  endtask

  typedef struct {
    logic rst, arm, vld, trg;
    int post, dec, st;
    logic wr;
    int addr, ta;
  } vec_t;
  vec_t tbl[25];

  function automatic vec_t mk(logic rst, arm, vld, trg, int post, dec, st, logic wr, int addr, ta);
    vec_t x;
    x.rst = rst; x.arm = arm; x.vld = vld; x.trg = trg; x.post = post; x.dec = dec;
    x.st = st; x.wr = wr; x.addr = addr; x.ta = ta;
    return x;
  endfunction

  initial begin
    logic [31:0] d;
    int pc, dc;
    logic t;
    {reset, cfg_arm, cfg_abort, sample_valid, trig_in} = '0;
    cfg_post_count = '0; cfg_decim = '0; sample_data = '0;
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 4, 0, 1, 0, 0, 0);
    for (int i = 2; i <= 6; i++) tbl[i] = mk(0, 0, 1, 0, 0, 0, 1, 1, i - 2, 0);
    tbl[7]  = mk(0, 0, 1, 1, 0, 0, 2, 1, 5, 6);
    tbl[8]  = mk(0, 0, 1, 1, 0, 0, 2, 1, 6, 6);
    tbl[9]  = mk(0, 0, 1, 1, 0, 0, 2, 1, 7, 6);
    tbl[10] = mk(0, 0, 1, 0, 0, 0, 2, 1, 8, 6);
    tbl[11] = mk(0, 0, 1, 0, 0, 0, 2, 1, 9, 6);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 3, 0, 9, 6);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 3, 0, 9, 6);
    tbl[14] = mk(0, 1, 0, 0, 4, 2, 1, 0, 9, 0);
    tbl[15] = mk(0, 0, 1, 0, 0, 0, 1, 0, 9, 0);
    tbl[16] = mk(0, 0, 1, 0, 0, 0, 1, 0, 9, 0);
    tbl[17] = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    tbl[18] = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[19] = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[20] = mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 0);
    tbl[21] = mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 0);
    tbl[22] = mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 0);
    tbl[23] = mk(0, 0, 1, 0, 0, 0, 1, 1, 2, 0);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 1, 0, 2, 0);
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].rst, tbl[i].arm, 0, tbl[i].post, tbl[i].dec, tbl[i].vld, 32'hA500_0000 + 32'(i), tbl[i].trg);
      chk("tbl_state", 32'(status_state), 32'(tbl[i].st));
      chk("tbl_write", 32'(ram_write), 32'(tbl[i].wr));
      chk("tbl_addr", 32'(ram_address), 32'(tbl[i].addr));
      chk("tbl_trig_addr", 32'(status_trig_addr), 32'(tbl[i].ta));
    end
    // Long pre-trigger run wraps the buffer before the trigger.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 100, 0, 0, 0, 0);
    for (int k = 0; k < 600; k++) step(0, 0, 0, 0, 0, 1, $urandom, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("wrap_set", 32'(status_wrapped), 32'd1);
    chk("trig_addr_88", 32'(status_trig_addr), 32'd88);
    chk("post_entered", 32'(status_state), 32'd2);
    for (int k = 0; k < 100; k++) step(0, 0, 0, 0, 0, 1, $urandom, 1);
    chk("last_post_addr", 32'(ram_address), 32'd187);
    chk("last_post_wr", 32'(ram_write), 32'd1);
    step(0, 0, 0, 0, 0, 1, $urandom, 0);
    chk("done_state", 32'(status_state), 32'd3);
    chk("done_flag", 32'(status_done), 32'd1);
    step(0, 0, 0, 0, 0, 1, $urandom, 0);
    chk("done_no_write", 32'(ram_write), 32'd0);
    // Zero post words with a sample accepted in the trigger cycle.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1, $urandom, 0);
    step(0, 0, 0, 0, 0, 1, 32'h1234_5678, 1);
    chk("p0_state", 32'(status_state), 32'd3);
    chk("p0_write", 32'(ram_write), 32'd1);
    chk("p0_addr", 32'(ram_address), 32'd3);
    chk("p0_trig_addr", 32'(status_trig_addr), 32'd4);
    step(0, 0, 0, 0, 0, 1, $urandom, 0);
    chk("p0_no_more", 32'(ram_write), 32'd0);
    // Abort mid-POST, arm with abort, reset mid-capture.
    step(0, 1, 0, 50, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 1, $urandom, 0);
    step(0, 0, 0, 0, 0, 1, $urandom, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1, $urandom, 0);
    step(0, 0, 1, 0, 0, 1, $urandom, 0);
    chk("abort_state", 32'(status_state), 32'd0);
    chk("abort_write", 32'(ram_write), 32'd0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1, $urandom, 0);
    chk("abort_quiet", 32'(ram_write), 32'd0);
    step(0, 1, 1, 10, 0, 1, $urandom, 0);
    chk("arm_abort_state", 32'(status_state), 32'd0);
    step(0, 0, 0, 0, 0, 1, $urandom, 0);
    chk("arm_abort_quiet", 32'(ram_write), 32'd0);
    step(0, 1, 0, 50, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1, $urandom, 0);
    step(1, 0, 0, 0, 0, 1, $urandom, 0);
    chk("rst_state", 32'(status_state), 32'd0);
    chk("rst_write", 32'(ram_write), 32'd0);
    chk("rst_done", 32'(status_done), 32'd0);
    step(0, 0, 0, 0, 0, 1, $urandom, 0);
    chk("rst_quiet", 32'(ram_write), 32'd0);
`ifdef CURRCTRL_DBG_TSTAMP_EN
    step(0, 1, 0, 511, 0, 0, 0, 0);
    for (int k = 0; k < 300; k++) begin
      d = $urandom;
      step(0, 0, 0, 0, 0, 1, d, 0);
      chk("ts_hi", 32'(ram_writedata[31:24]), 32'(k % 256));
      chk("ts_lo", 32'(ram_writedata[23:0]), 32'(d[23:0]));
    end
    step(0, 0, 1, 0, 0, 0, 0, 0);
`endif
    // Random traffic.
    t = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      if ($urandom_range(0, 15) == 0) t = ~t;
      pc = ($urandom_range(0, 40) == 0) ? 511 : $urandom_range(0, 40);
      dc = $urandom_range(0, 3);
      step($urandom_range(0, 999) == 0,
           ((m_state == 0 || m_state == 3) && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0,
           $urandom_range(0, 299) == 0, pc, dc, $urandom_range(0, 3) != 0, $urandom, t);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/currctrl_debug_capture_ctrl.md
Name: currctrl_debug_capture_ctrl

Overview:
Sequences the 512x32 CurrCTRL debug RAM as a circular capture buffer for current-loop samples.
- Drives the RAM's second (write-side) port with decimated samples.
- Detects a trigger, records a programmed number of post-trigger words, then freezes and flags done.
- The CPU reads the captured window through the RAM's first port.
- Sits between the current-control datapath (sample source) and the debug RAM; configured by CSR logic.

Parameters:
ADDR_W, 9, RAM address width; depth = 2**ADDR_W.
DATA_W, 32, sample/RAM word width.
DECIM_W, 8, width of decimation divider.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
cfg_arm  in  1  single-cycle pulse; start capture.
cfg_abort  in  1  single-cycle pulse; stop capture, return to IDLE.
cfg_post_count  in  ADDR_W  post-trigger words to record; sampled on arm.
cfg_decim  in  DECIM_W  write one of every (cfg_decim+1) valid samples; sampled on arm.
sample_valid  in  1  sample_data qualifier.
sample_data  in  DATA_W  sample word from the current loop.
trig_in  in  1  level trigger; rising edge is the event.
ram_address  out  ADDR_W  RAM port-2 address.
ram_writedata  out  DATA_W  RAM port-2 write data.
ram_byteenable  out  DATA_W/8  all ones whenever ram_write=1, else 0.
ram_chipselect  out  1  RAM port-2 select.
ram_write  out  1  RAM port-2 write strobe.
status_state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
status_done  out  1  high in DONE.
status_wrapped  out  1  write pointer has wrapped since arm.
status_trig_addr  out  ADDR_W  address of the first post-trigger word.

Behaviour:
- Reset: state IDLE. All outputs 0. wr_ptr, decim_cnt, post_cnt and trig edge register cleared.
- IDLE/DONE + cfg_arm:
  - Next state ARMED.
  - wr_ptr=0, wrapped=0, decim_cnt=0, trig_addr=0.
  - Latch cfg_decim and cfg_post_count.
  - status_done clears.
- cfg_arm in ARMED/POST: ignored.
- cfg_abort in any state: next state IDLE; no further writes. Abort and arm in the same cycle: abort wins.
- Sample acceptance (ARMED/POST only):
  - On sample_valid: if decim_cnt==decim_latched, accept the sample and set decim_cnt=0; else increment decim_cnt.
  - decim_latched=0 accepts every valid sample.
- Write timing:
  - Accepted sample is registered.
  - Next cycle: ram_chipselect=ram_write=1 for exactly one cycle, ram_address=wr_ptr, ram_writedata=registered word.
  - Latency from sample_valid to strobe is 1 cycle.
  - ram_address holds its last value when idle.
- wr_ptr increments after each write; wraps 2**ADDR_W-1 -> 0 and sets wrapped (sticky until next arm).
- Trigger:
  - trig_in registered once; event = trig_in & ~trig_q.
  - Only events in ARMED count; they move the state to POST.
  - trig_addr = wr_ptr value after any write accepted in the trigger cycle, so a sample accepted in the same cycle as the trigger is pre-trigger.
- POST:
  - post_cnt counts writes issued.
  - When post_cnt reaches post_latched -> DONE on the cycle after the last strobe.
  - post_latched=0: DONE the cycle after the trigger, zero post writes.
  - A sample already in the pipeline at the DONE transition is still written.
- Max post_count (2**ADDR_W-1): the buffer keeps 1 pre-trigger word.
- DONE: no writes; status holds until arm, abort or reset.
- Reset mid-capture: immediate IDLE on the next edge; any pending strobe is dropped.

Optional Feature:
CURRCTRL_DBG_TSTAMP_EN
- Defined: ram_writedata[DATA_W-1:DATA_W-8] is replaced by an 8-bit count of accepted samples since arm (starts at 0, wraps 255->0). Lower bits carry sample_data unchanged.
- Undefined: sample_data is written unmodified and no counter logic exists.

Decomposition:
- Package currctrl_dbg_pkg:
  - state enum (IDLE/ARMED/POST/DONE, 2-bit encoding above).
  - DBG_ADDR_W=9, DBG_DATA_W=32, DBG_DEPTH=512.
- One sub-module: currctrl_dbg_decimator (decim_cnt, latched divider, accept strobe; cleared on arm/reset).

Test Plan:
- Reset, then arm with decim=0, post=4. Drive 10 valid samples, trigger on the 6th. -> Writes at addresses 0..9; trig_addr=6; DONE after address 9; state=3.
- decim=2, 9 continuous valid samples -> writes only for samples 3, 6, 9, at addresses 0, 1, 2.
- post=100, 600 pre-trigger samples -> wrapped=1; wr_ptr=88 at trigger; trig_addr=88; 100 post writes end at address 187.
- post=0, trigger while a sample is accepted in the same cycle -> that sample is written; trig_addr=ptr+1; DONE next cycle; no further writes.
- Abort mid-POST, arm and abort in the same cycle, reset mid-capture -> IDLE; ram_write=0 thereafter; status_done=0.
- With CURRCTRL_DBG_TSTAMP_EN, 300 accepted samples -> word[31:24] equals 0..255, then 0..43; word[23:0] equals sample_data[23:0].
